mna_flit_sender: RTL and testbench

- Master-side NoC adapter stage that sits directly downstream of the MNA flit builder.
- Accepts one request packet per handshake: header/body/tail flits (34 bits each) plus the awrite flag.
- Injects the packet into the local router one flit per cycle, paced by credit-based flow control.
- Write packets are 3 flits (header, body = address, tail = wdata); read packets are 2 flits (header, tail = address).

---
 rtl/mna_flit_sender.sv | 168 ++++++++++++++++
 tb/tb_mna_flit_sender.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mna_flit_sender.sv
// ---------------------------------------------------------------------------
// mna_flit_sender
//
// Master-side NoC adapter stage downstream of the MNA flit builder. It
// captures one request packet per handshake and injects it into the local
// router one flit per cycle. Credit-based flow control paces the injection.
// Write packets carry header, body (address) and tail (wdata). Read packets
// carry header and tail (address); their body flit is never sent.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   req_valid    builder flits and awrite are valid
//   req_ready    sender can accept a packet (state == IDLE)
//   awrite       1 = write packet (3 flits), 0 = read packet (2 flits)
//   header       header flit [33:0]
//   body         body flit [33:0], ignored for reads
//   tail         tail flit [33:0]
//   flit_out     flit to router, holds its value while flit_valid = 0
//   flit_valid   flit_out valid this cycle
//   credit_in    one-cycle pulse, router freed one buffer slot
//   busy         packet in progress (state != IDLE)
//   packet_sent  one-cycle pulse coincident with the tail flit
//   credit_err   sticky, credit returned while the counter was already full
// ---------------------------------------------------------------------------
module mna_flit_sender #(
    parameter int unsigned NUM_CREDITS = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        awrite,
    input  logic [33:0] header,
    input  logic [33:0] body,
    input  logic [33:0] tail,
    output logic [33:0] flit_out,
    output logic        flit_valid,
    input  logic        credit_in,
    output logic        busy,
    output logic        packet_sent,
    output logic        credit_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_CREDITS);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] credit_cnt;
    logic [33:0]      hdr_q;
    logic [33:0]      body_q;
    logic [33:0]      tail_q;
    logic             awrite_q;
    logic             issue_s;

    // Handshake and status flags are plain decodes of the state register.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // A flit leaves this cycle whenever a packet is in flight and a credit is held.
    always_comb begin
        issue_s = 1'b0;
        case (state)
            IDLE:            issue_s = 1'b0;
            HDR, BODY, TAIL: issue_s = (credit_cnt != CNT_ZERO);
            default:         issue_s = 1'b0;
        endcase
    end

    // Packet FSM: captures the request in IDLE and issues flits with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hdr_q       <= 34'd0;
            body_q      <= 34'd0;
            tail_q      <= 34'd0;
            awrite_q    <= 1'b0;
            flit_out    <= 34'd0;
            flit_valid  <= 1'b0;
            packet_sent <= 1'b0;
        end else begin
            // Single-cycle strobes; overridden below in the cycle a flit is issued.
            flit_valid  <= 1'b0;
            packet_sent <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        hdr_q    <= header;
                        body_q   <= body;
                        tail_q   <= tail;
                        awrite_q <= awrite;
                        state    <= HDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                HDR: begin
                    if (issue_s) begin
                        flit_out   <= hdr_q;
                        flit_valid <= 1'b1;
                        // Reads skip the body flit entirely.
                        state      <= awrite_q ? BODY : TAIL;
                    end else begin
                        state <= HDR;
                    end
                end
                BODY: begin
                    if (issue_s) begin
                        flit_out   <= body_q;
                        flit_valid <= 1'b1;
                        state      <= TAIL;
                    end else begin
                        state <= BODY;
                    end
                end
                TAIL: begin
                    if (issue_s) begin
                        flit_out    <= tail_q;
                        flit_valid  <= 1'b1;
                        packet_sent <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= TAIL;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Credit counter: one credit spent per issued flit, one regained per credit_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CNT_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({issue_s, credit_in})
                2'b10: begin
                    credit_cnt <= credit_cnt - CNT_ONE;
                end
                2'b01: begin
                    // A return beyond the buffer depth means the router and sender disagree.
                    if (credit_cnt == CNT_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Idle cycle, or a spent and a returned credit cancelling out.
                    credit_cnt <= credit_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mna_flit_sender.sv
// ---------------------------------------------------------------------------
// tb_mna_flit_sender
//
// Self-checking bench for mna_flit_sender. A reference model keeps the
// packet as a queue of pending flits plus an integer credit count and
// predicts every output after each rising edge. A table of hand-computed
// vectors, hand-written stall/reset/hold sequences and a randomized phase
// drive the design.
// ---------------------------------------------------------------------------
module tb_mna_flit_sender;

    localparam int NUM_CREDITS = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        awrite;
    logic [33:0] header;
    logic [33:0] body;
    logic [33:0] tail;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        credit_in;
    logic        busy;
    logic        packet_sent;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [33:0] mq[$];
    int          mcred;
    logic        merr;
    logic [33:0] exp_out;
    logic        exp_valid;
    logic        exp_sent;

    typedef struct {
        logic        rv;
        logic        aw;
        logic [33:0] h;
        logic [33:0] b;
        logic [33:0] t;
        logic        ci;
        logic        ev;
        logic [33:0] eo;
        logic        es;
        logic        er;
    } vec_t;

    vec_t tbl [0:7];

    mna_flit_sender #(
        .NUM_CREDITS(4),
        .CNT_W(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .awrite     (awrite),
        .header     (header),
        .body       (body),
        .tail       (tail),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .credit_in  (credit_in),
        .busy       (busy),
        .packet_sent(packet_sent),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcred     = NUM_CREDITS;
        merr      = 1'b0;
        exp_out   = 34'd0;
        exp_valid = 1'b0;
        exp_sent  = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held before the edge.
    task automatic model_edge();
        bit issued;
        issued    = 1'b0;
        exp_valid = 1'b0;
        exp_sent  = 1'b0;
        if (mq.size() == 0) begin
            if (req_valid) begin
                mq.push_back(header);
                if (awrite) mq.push_back(body);
                mq.push_back(tail);
            end
        end else if (mcred > 0) begin
            exp_out   = mq.pop_front();
            exp_valid = 1'b1;
            issued    = 1'b1;
            exp_sent  = (mq.size() == 0);
        end
        if (credit_in && !issued) begin
            if (mcred == NUM_CREDITS) merr = 1'b1;
            else mcred = mcred + 1;
        end else if (!credit_in && issued) begin
            mcred = mcred - 1;
        end
    endtask

    task automatic check_model();
        chk("flit_valid", 64'(flit_valid), 64'(exp_valid));
        chk("flit_out", 64'(flit_out), 64'(exp_out));
        chk("packet_sent", 64'(packet_sent), 64'(exp_sent));
        chk("req_ready", 64'(req_ready), 64'(mq.size() == 0));
        chk("busy", 64'(busy), 64'(mq.size() != 0));
        chk("credit_err", 64'(credit_err), 64'(merr));
        chk("credit_cnt", 64'(dut.credit_cnt), 64'(mcred));
    endtask

    // Advance one clock, step the model, then sample away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        credit_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model();
    endtask

    function automatic logic [33:0] rnd_flit(input logic [1:0] kind);
        logic [33:0] f;
        f = {kind, $urandom()};
        return f;
    endfunction

    logic [33:0] b2;
    logic [33:0] t2;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        awrite    = 1'b0;
        header    = 34'd0;
        body      = 34'd0;
        tail      = 34'd0;
        credit_in = 1'b0;
        model_reset();

        // Reset state
        #3;
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit_out", 64'(flit_out), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_credit_cnt", 64'(dut.credit_cnt), 64'd4);
        apply_reset();

        // Write packet then read packet, hand-computed expectations.
        tbl[0] = '{1'b1, 1'b1, 34'h2_0000_1220, 34'h0_1000_0004, 34'h1_DEAD_BEEF, 1'b0, 1'b0, 34'h0_0000_0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b0, 1'b1, 34'h2_0000_1220, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b0, 1'b1, 34'h0_1000_0004, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b0, 1'b1, 34'h1_DEAD_BEEF, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 34'h2_0000_2330, 34'h0_5555_5555, 34'h1_2000_0010, 1'b1, 1'b0, 34'h1_DEAD_BEEF, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b1, 1'b1, 34'h2_0000_2330, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b0, 1'b1, 34'h1_2000_0010, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 34'h0_0000_0000, 34'h0_0000_0000, 34'h0_0000_0000, 1'b0, 1'b0, 34'h1_2000_0010, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].rv;
            awrite    = tbl[i].aw;
            header    = tbl[i].h;
            body      = tbl[i].b;
            tail      = tbl[i].t;
            credit_in = tbl[i].ci;
            tick();
            chk("tbl_flit_valid", 64'(flit_valid), 64'(tbl[i].ev));
            chk("tbl_flit_out", 64'(flit_out), 64'(tbl[i].eo));
            chk("tbl_packet_sent", 64'(packet_sent), 64'(tbl[i].es));
            chk("tbl_req_ready", 64'(req_ready), 64'(tbl[i].er));
            if (i == 3) chk("tbl_cnt_after_write", 64'(dut.credit_cnt), 64'd1);
            if (i == 5) chk("tbl_cnt_issue_and_credit", 64'(dut.credit_cnt), 64'd2);
        end
        chk("tbl_cnt_after_read", 64'(dut.credit_cnt), 64'd1);

        // Zero-credit stall in the middle of a write packet.
        apply_reset();
        req_valid = 1'b1; awrite = 1'b1;
        header = 34'h2_0000_0001; body = 34'h0_0000_0002; tail = 34'h1_0000_0003;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        req_valid = 1'b1;
        b2 = 34'h0_ABCD_0002; t2 = 34'h1_ABCD_0003;
        header = 34'h2_ABCD_0001; body = b2; tail = t2;
        tick();
        req_valid = 1'b0;
        tick();
        chk("stall_hdr_issued", 64'(flit_valid), 64'd1);
        repeat (2) tick();
        chk("stall_valid_low", 64'(flit_valid), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        credit_in = 1'b1;
        tick();
        chk("stall_credit_edge_no_issue", 64'(flit_valid), 64'd0);
        credit_in = 1'b0;
        tick();
        chk("stall_body_valid", 64'(flit_valid), 64'd1);
        chk("stall_body_flit", 64'(flit_out), 64'(b2));
        tick();
        chk("stall_again_hold", 64'(flit_out), 64'(b2));
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        chk("stall_tail_flit", 64'(flit_out), 64'(t2));
        chk("stall_tail_sent", 64'(packet_sent), 64'd1);

        // Credit returned while already full and idle.
        apply_reset();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        chk("credit_err_set", 64'(credit_err), 64'd1);
        chk("credit_err_cnt", 64'(dut.credit_cnt), 64'd4);

        // Asynchronous reset between header and body of a write.
        req_valid = 1'b1; awrite = 1'b1;
        header = 34'h2_0000_00AA; body = 34'h0_0000_00BB; tail = 34'h1_0000_00CC;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_hdr", 64'(flit_out), 64'h2_0000_00AA);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(flit_valid), 64'd0);
        chk("async_rst_flit", 64'(flit_out), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd1);
        chk("async_rst_cnt", 64'(dut.credit_cnt), 64'd4);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b1; awrite = 1'b0;
        header = 34'h2_0000_0777; tail = 34'h1_0000_0888;
        tick();
        req_valid = 1'b0;
        tick();
        chk("post_rst_header_first", 64'(flit_out), 64'h2_0000_0777);
        tick();

        // req_valid held high with changing inputs while a packet is in flight.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            awrite    = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            header    = rnd_flit(2'b10);
            body      = rnd_flit(2'b00);
            tail      = rnd_flit(2'b01);
            credit_in = (i % 2 == 1) ? 1'b1 : 1'b0;
            tick();
        end

        // Randomized traffic against the reference model.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            awrite    = 1'($urandom_range(0, 1));
            header    = rnd_flit(2'b10);
            body      = rnd_flit(2'b00);
            tail      = rnd_flit(2'b01);
            credit_in = ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
